zap_mult_seq: RTL

- Multi-cycle sequencer that builds a 32x32 -> 64-bit multiply (optionally accumulate, signed or unsigned) from a single shared 17x17 signed multiplier (mult16x16) by issuing four partial products over four cycles.
- Sits in the ALU/multiply stage and serves MUL/MLA/UMULL/SMULL/UMLAL/SMLAL-class operations.
- Holds the pipeline through o_busy and reports completion through a one-cycle o_done pulse.

---
 rtl/zap_mult_seq_pkg.sv | 14 +
 rtl/zap_mult_seq_mult16x16.sv | 10 +
 rtl/zap_mult_seq.sv | 86 ++++++++
 3 files changed

// File: rtl/zap_mult_seq_pkg.sv
// zap_mult_seq_pkg: state encodings and partial-product shift amounts for the multiply sequencer
package zap_mult_seq_pkg;
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PP0  = 3'd1,
    ST_PP1  = 3'd2,
    ST_PP2  = 3'd3,
    ST_PP3  = 3'd4,
    ST_DONE = 3'd5
  } state_t;
  localparam logic [5:0] SH_0  = 6'd0;
  localparam logic [5:0] SH_16 = 6'd16;
  localparam logic [5:0] SH_32 = 6'd32;
endpackage

// File: rtl/zap_mult_seq_mult16x16.sv
// mult16x16: combinational 17x17 signed multiplier, sign-extended to 64 bits
module mult16x16 (
  input  logic signed [16:0] a,
  input  logic signed [16:0] b,
  output logic signed [63:0] p
);
  logic signed [33:0] prod;
  assign prod = a * b;
  assign p = {{30{prod[33]}}, prod};
endmodule

// File: rtl/zap_mult_seq.sv
// zap_mult_seq: 32x32->64 (multiply-)accumulate built from four 17x17 partial products
module zap_mult_seq
  import zap_mult_seq_pkg::*;
#(
  parameter int ACC_W = 64
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_start,
  input  logic             i_signed,
  input  logic             i_acc_en,
  input  logic [31:0]      i_a,
  input  logic [31:0]      i_b,
  input  logic [ACC_W-1:0] i_acc,
  input  logic             i_flush,
  output logic             o_ready,
  output logic             o_busy,
  output logic             o_done,
  output logic [ACC_W-1:0] o_result
);
  state_t state, state_nxt;
  logic [31:0] a_r, b_r;
  logic sgn_r;
  logic [ACC_W-1:0] acc, pp;
  logic signed [16:0] al, ah, bl, bh, ma, mb;
  logic signed [63:0] mp;
  logic [5:0] sh;
  logic accept, lo_a, lo_b, hi_a, hi_b;
  assign accept = (state == ST_IDLE) && i_start && !i_flush;
  assign al = {1'b0, a_r[15:0]};
  assign ah = {sgn_r & a_r[31], a_r[31:16]};
  assign bl = {1'b0, b_r[15:0]};
  assign bh = {sgn_r & b_r[31], b_r[31:16]};
  assign lo_a = (state == ST_PP0) || (state == ST_PP1);
  assign hi_a = (state == ST_PP2) || (state == ST_PP3);
  assign lo_b = (state == ST_PP0) || (state == ST_PP2);
  assign hi_b = (state == ST_PP1) || (state == ST_PP3);
  // operand selection per partial-product state; zero outside PP states keeps the multiplier quiet
  always_comb begin
    ma = lo_a ? al : hi_a ? ah : '0;
    mb = lo_b ? bl : hi_b ? bh : '0;
    sh = (state == ST_PP0) ? SH_0 : (state == ST_PP3) ? SH_32 : SH_16;
  end
  mult16x16 u_mult (
    .a(ma),
    .b(mb),
    .p(mp)
  );
  assign pp = mp << sh;
  // next-state: four PP cycles then a single DONE cycle; flush aborts PP states only
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: state_nxt = accept ? ST_PP0 : ST_IDLE;
      ST_PP0:  state_nxt = i_flush ? ST_IDLE : ST_PP1;
      ST_PP1:  state_nxt = i_flush ? ST_IDLE : ST_PP2;
      ST_PP2:  state_nxt = i_flush ? ST_IDLE : ST_PP3;
      ST_PP3:  state_nxt = i_flush ? ST_IDLE : ST_DONE;
      default: state_nxt = ST_IDLE;
    endcase
  end
  // state register
  always_ff @(posedge i_clk or negedge i_reset_n)
    if (!i_reset_n) state <= ST_IDLE;
    else state <= state_nxt;
  // operand capture, accumulation and result latch; result only moves on a completed PP3
  always_ff @(posedge i_clk or negedge i_reset_n)
    if (!i_reset_n) begin
      a_r <= '0;
      b_r <= '0;
      sgn_r <= 1'b0;
      acc <= '0;
      o_result <= '0;
    end else begin
      if (accept) begin
        a_r <= i_a;
        b_r <= i_b;
        sgn_r <= i_signed;
        acc <= i_acc_en ? i_acc : '0;
      end else if (lo_a || hi_a) acc <= acc + pp;
      if (state == ST_PP3 && !i_flush) o_result <= acc + pp;
    end
  assign o_ready = state == ST_IDLE;
  assign o_busy = state != ST_IDLE;
  assign o_done = state == ST_DONE;
endmodule
